// File: rtl/aes_pkg.sv
// Shared AES definitions for the encrypt/decrypt cores: FSM encoding, round count
// and the byte/word-level transforms of FIPS-197 on a column-major 128-bit state.
package aes_pkg;

    localparam int AES128_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte i of the state lives at [127-8*i -: 8]; row = i % 4, column = i / 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = s;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = s;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// START/DONE handshake and 128-bit key/message bus of the AES encryption core.
interface aes_encrypt_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] msg_dec;
    logic         done;
    logic [127:0] msg_enc;

    modport master (output start, key, msg_dec, input done, msg_enc);
    modport slave  (input start, key, msg_dec, output done, msg_enc);
endinterface

// File: rtl/aes_encrypt_sbox.sv
// Forward AES S-box, purely combinational; instanced per byte for SubBytes and SubWord.
module aes_sbox (
    input  logic [7:0] b,
    output logic [7:0] s
);
    always_comb begin
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end
endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption: one round per clock with on-the-fly key expansion.
//   state    | meaning
//   ST_IDLE  | waiting for start; initial AddRoundKey captured on start
//   ST_ROUND | one cipher round and one key-schedule step per clock
//   ST_DONE  | ciphertext valid; held until start is seen low
module aes_encrypt
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic          clk,
    input  logic          reset,
    aes_encrypt_if.slave  bus
);

    if (NR != AES128_NR) begin : g_nr_check
        $fatal(1, "aes_encrypt supports only AES-128 (NR = 10)");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t       fsm, fsm_nx;
    logic [127:0] st, st_nx;
    logic [127:0] rk, rk_nx;
    logic [127:0] enc, enc_nx;
    logic [7:0]   rcon, rcon_nx;
    logic [3:0]   rnd, rnd_nx;
    logic         done, done_nx;

    logic [127:0] sb, sr, nk, round_out;
    logic [31:0]  rot, sw, t;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (.b(st[127-8*i -: 8]), .s(sb[127-8*i -: 8]));
    end

    for (genvar j = 0; j < 4; j++) begin : g_sub_word
        aes_sbox u_sbox (.b(rot[31-8*j -: 8]), .s(sw[31-8*j -: 8]));
    end

    // Next round key: each word folds in the word just produced.
    assign rot         = rot_word(rk[31:0]);
    assign t           = sw ^ {rcon, 24'h000000};
    assign nk[127:96]  = rk[127:96] ^ t;
    assign nk[95:64]   = rk[95:64]  ^ nk[127:96];
    assign nk[63:32]   = rk[63:32]  ^ nk[95:64];
    assign nk[31:0]    = rk[31:0]   ^ nk[63:32];

    assign sr        = shift_rows(sb);
    assign round_out = (rnd == LAST_RND) ? (sr ^ nk) : (mix_columns(sr) ^ nk);

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm  <= ST_IDLE;
            st   <= '0;
            rk   <= '0;
            enc  <= '0;
            rcon <= '0;
            rnd  <= '0;
            done <= 1'b0;
        end else begin
            fsm  <= fsm_nx;
            st   <= st_nx;
            rk   <= rk_nx;
            enc  <= enc_nx;
            rcon <= rcon_nx;
            rnd  <= rnd_nx;
            done <= done_nx;
        end
    end

    always_comb begin
        fsm_nx  = fsm;
        st_nx   = st;
        rk_nx   = rk;
        enc_nx  = enc;
        rcon_nx = rcon;
        rnd_nx  = rnd;
        done_nx = done;
        case (fsm)
            ST_IDLE: begin
                if (bus.start) begin
                    st_nx   = bus.msg_dec ^ bus.key;
                    rk_nx   = bus.key;
                    rcon_nx = 8'h01;
                    rnd_nx  = 4'd1;
                    fsm_nx  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                st_nx   = round_out;
                rk_nx   = nk;
                rcon_nx = xtime(rcon);
                rnd_nx  = rnd + 4'd1;
                if (rnd == LAST_RND) begin
                    enc_nx  = round_out;
                    done_nx = 1'b1;
                    fsm_nx  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.start) begin
                    done_nx = 1'b0;
                    fsm_nx  = ST_IDLE;
                end
            end
            default: fsm_nx = ST_IDLE;
        endcase
    end

    assign bus.done    = done;
    assign bus.msg_enc = enc;

endmodule

// File: tb/tb_aes_encrypt.sv
// Directed FIPS-197 vectors; expected ciphertexts are queued at issue and a
// separate monitor pops and compares them on each rising AES done.
module tb_aes_encrypt;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P3 = 128'hece298dcece298dcece298dcece298dc;
    localparam logic [127:0] C3 = 128'hdaec3055df058e1c39e814ea76f6747e;

    logic clk = 1'b0;
    logic reset;
    aes_encrypt_if bus ();

    aes_encrypt #(.NR(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q[$];
    logic done_q = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.done === 1'b1 && done_q == 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got %h expected no result", bus.msg_enc);
            end else begin
                check("result", bus.msg_enc, exp_q.pop_front());
            end
        end
        done_q <= bus.done;
    end

    task automatic start_op(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
        @(negedge clk);
        bus.key     = k;
        bus.msg_dec = p;
        bus.start   = 1'b1;
        exp_q.push_back(e);
    endtask

    // Counts edges from the next one (E0) until done reads high, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.key     = '0;
        bus.msg_dec = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 128'(bus.done), 128'd0);
        check("reset_enc", bus.msg_enc, 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // C.1 with START held high through DONE
        start_op(K1, P1, C1);
        wait_done(n);
        check("c1_latency", 128'(n), 128'd11);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("hold_done", 128'(bus.done), 128'd1);
            check("hold_enc", bus.msg_enc, C1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("drop_done", 128'(bus.done), 128'd0);
        check("drop_enc", bus.msg_enc, C1);

        // App. B after a completed handshake
        start_op(K2, P2, C2);
        wait_done(n);
        check("b_latency", 128'(n), 128'd11);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("b_drop_done", 128'(bus.done), 128'd0);

        // Single-cycle START; inputs scrambled after E3 must not matter
        start_op(K1, P3, C3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.key     = 128'hffeeddccbbaa99887766554433221100;
        bus.msg_dec = 128'h0123456789abcdef0123456789abcdef;
        wait_done(n);
        check("pulse_latency", 128'(n + 4), 128'd11);
        @(posedge clk);
        #1;
        check("pulse_width", 128'(bus.done), 128'd0);
        check("pulse_enc_kept", bus.msg_enc, C3);

        // Reset at E5 mid-operation, then restart with START held
        @(negedge clk);
        bus.key     = K1;
        bus.msg_dec = P1;
        bus.start   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", 128'(bus.done), 128'd0);
        check("abort_enc", bus.msg_enc, 128'd0);
        @(posedge clk);
        #1;
        check("abort_hold_done", 128'(bus.done), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(C1);
        wait_done(n);
        check("restart_latency", 128'(n), 128'd11);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drain", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
